thread_regfile_bank: RTL and testbench
======================================

THREAD_REGFILE_BANK -- requirements
Module: thread_regfile_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register data width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 16, registers per thread including the 3 read-only registers; legal range 4..64.
REQ-003 SHALL have parameter NUM_THREADS, default 4, number of SIMD lanes, each with a private register bank.
REQ-004 SHALL have derived constant ADDR_W = clog2(NUM_REGS).
REQ-005 SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports rd_addr1, rd_addr2  in  ADDR_W  read addresses, broadcast to all lanes.
REQ-008 SHALL have port rd_en  in  1  captures both read addresses for this cycle.
REQ-009 SHALL have ports rd_data1, rd_data2  out  NUM_THREADS*DATA_W  registered read data, lane i in bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port rd_valid  out  1  rd_data1/rd_data2 are valid this cycle.
REQ-011 SHALL have ports wr_en  in  1;  wr_addr  in  ADDR_W;  wr_mask  in  NUM_THREADS  per-lane write enable;  wr_data  in  NUM_THREADS*DATA_W.
REQ-012 SHALL have port wr_clear  in  1  the write is a load writeback; clears the scoreboard bit of wr_addr.
REQ-013 SHALL have ports rsv_en  in  1;  rsv_addr  in  ADDR_W  mark a register pending for an outstanding load.
REQ-014 SHALL have ports busy1, busy2  out  1  combinational: scoreboard bit of rd_addr1 / rd_addr2.
REQ-015 SHALL have ports block_id, threads_per_block  in  DATA_W  sources of the read-only registers.
REQ-016 SHALL have ports err_ro_write, err_double_rsv  out  1  one-cycle error pulses.

Function
REQ-017 SHALL map address NUM_REGS-3 to block_id, NUM_REGS-2 to threads_per_block, NUM_REGS-1 to lane index i (zero-extended to DATA_W); all lower addresses are general-purpose storage.
REQ-018 SHALL have one-cycle read latency: rd_en at edge N gives rd_data*/rd_valid at edge N+1; rd_valid low otherwise; rd_data* hold last value when rd_valid low.
REQ-019 SHALL forward write data: when wr_en, wr_mask[i] and wr_addr equals a read address in the same cycle, lane i returns the new wr_data, not the stored value.
REQ-020 SHALL write lane i storage at wr_addr only when wr_en and wr_mask[i] and wr_addr < NUM_REGS-3.
REQ-021 SHALL ignore writes to read-only addresses (no storage change, no forwarding) and pulse err_ro_write next cycle; wr_clear on a read-only address has no effect.
REQ-022 SHALL keep one scoreboard bit per general-purpose address, shared by all lanes.
REQ-023 SHALL set the bit of rsv_addr on rsv_en; rsv_en on an already-set bit keeps it set and pulses err_double_rsv next cycle; rsv_en on a read-only address is ignored.
REQ-024 SHALL clear the bit of wr_addr when wr_en and wr_clear, regardless of wr_mask (including all-zero mask).
REQ-025 SHALL leave the bit set when rsv_en and a clearing write target the same address in one cycle (new reservation wins; no error pulse).
REQ-026 SHALL reflect a same-cycle rsv_en in busy1/busy2 only from the next cycle (bits are registered, outputs read current state).
REQ-027 SHALL treat out-of-range addresses (>= NUM_REGS when NUM_REGS is not a power of 2) as reading zero, never busy, writes ignored with err_ro_write pulse.

Reset
REQ-028 SHALL on reset clear all general-purpose storage, all scoreboard bits, rd_data1/rd_data2, rd_valid, err_ro_write and err_double_rsv to 0.
REQ-029 SHALL let reset override all same-cycle rd_en, wr_en and rsv_en; a read in flight at reset produces no rd_valid.

Structure
REQ-030 SHALL place read-only address offsets (RO_BLOCK_ID=3, RO_TPB=2, RO_TID=1 below NUM_REGS) in the shared GPU package.
REQ-031 SHALL implement one lane bank as sub-module lane_regbank (storage, read mux, forwarding), instantiated NUM_THREADS times; the scoreboard and error logic stay in the top.

Verification
REQ-032 SHALL cover: reset, write lanes 0..3 R2 = 0x11,0x22,0x33,0x44 mask 4'b1111, rd_addr1=2 -> next cycle rd_data1 = {0x44,0x33,0x22,0x11}, rd_valid=1.
REQ-033 SHALL cover: wr R5=0xAA mask 4'b0101 with rd_addr2=5 same cycle -> rd_data2 lanes 0,2 = 0xAA, lanes 1,3 = previous value.
REQ-034 SHALL cover: block_id=0x07, threads_per_block=0x04, read addresses 13,15 -> lane i returns 0x07 and i; write to R14 -> err_ro_write pulse, R14 still 0x04.
REQ-035 SHALL cover: rsv R3, next cycle busy1=1 for rd_addr1=3; rsv R3 again -> err_double_rsv; wr_clear R3 mask 0 -> busy1=0.
REQ-036 SHALL cover: rsv R6 and clearing write R6 same cycle -> busy stays 1, no error pulse.
REQ-037 SHALL cover: reset asserted the cycle after rd_en with R2 nonzero -> rd_valid stays 0, all storage and busy bits 0.

Source files
------------

// File: rtl/thread_regfile_bank_pkg.sv
// Shared constants for the SIMD thread register file: read-only register
// offsets counted down from the top of each lane's address space.
package thread_regfile_bank_pkg;

    localparam int RO_BLOCK_ID = 3;
    localparam int RO_TPB      = 2;
    localparam int RO_TID      = 1;

    // Count of general-purpose (writable) registers below the read-only window.
    function automatic int gp_regs(input int num_regs);
        return num_regs - RO_BLOCK_ID;
    endfunction

endpackage

// File: rtl/lane_regbank.sv
// One SIMD lane: general-purpose storage, read-only register mux and
// same-cycle write forwarding, with registered dual read ports.
module lane_regbank
    import thread_regfile_bank_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    parameter int LANE_ID  = 0,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              wr_we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] block_id,
    input  logic [DATA_W-1:0] threads_per_block,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    localparam int                GP_REGS = gp_regs(NUM_REGS);
    localparam logic [ADDR_W-1:0] GP_LIM  = ADDR_W'(GP_REGS);
    localparam logic [ADDR_W-1:0] A_BID   = ADDR_W'(NUM_REGS - RO_BLOCK_ID);
    localparam logic [ADDR_W-1:0] A_TPB   = ADDR_W'(NUM_REGS - RO_TPB);
    localparam logic [ADDR_W-1:0] A_TID   = ADDR_W'(NUM_REGS - RO_TID);

    logic [GP_REGS-1:0][DATA_W-1:0] mem_q;
    logic [DATA_W-1:0]              rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0]              rd_data2_q, rd_data2_d;

    // wr_we arrives already qualified to general-purpose addresses, so
    // forwarding can never leak a write into the read-only window.
    function automatic logic [DATA_W-1:0] sel(
        input logic [ADDR_W-1:0]                a,
        input logic [GP_REGS-1:0][DATA_W-1:0]   mem,
        input logic                             fwd,
        input logic [DATA_W-1:0]                fwd_data,
        input logic [DATA_W-1:0]                bid,
        input logic [DATA_W-1:0]                tpb
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (a < GP_LIM)
            v = fwd ? fwd_data : mem[a];
        else if (a == A_BID)
            v = bid;
        else if (a == A_TPB)
            v = tpb;
        else if (a == A_TID)
            v = DATA_W'(LANE_ID);
        return v;
    endfunction

    always_comb begin
        rd_data1_d = sel(rd_addr1, mem_q, wr_we && (wr_addr == rd_addr1), wr_data,
                         block_id, threads_per_block);
        rd_data2_d = sel(rd_addr2, mem_q, wr_we && (wr_addr == rd_addr2), wr_data,
                         block_id, threads_per_block);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q      <= '0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
        end else begin
            if (wr_we)
                mem_q[wr_addr] <= wr_data;
            if (rd_en) begin
                rd_data1_q <= rd_data1_d;
                rd_data2_q <= rd_data2_d;
            end
        end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;

endmodule

// File: rtl/thread_regfile_bank.sv
// Per-thread register banks for a SIMD core, plus the shared load scoreboard
// and the read-only-write / double-reservation error pulses.
module thread_regfile_bank
    import thread_regfile_bank_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int NUM_REGS    = 16,
    parameter  int NUM_THREADS = 4,
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             rd_addr1,
    input  logic [ADDR_W-1:0]             rd_addr2,
    input  logic                          rd_en,
    output logic [NUM_THREADS*DATA_W-1:0] rd_data1,
    output logic [NUM_THREADS*DATA_W-1:0] rd_data2,
    output logic                          rd_valid,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [NUM_THREADS-1:0]        wr_mask,
    input  logic [NUM_THREADS*DATA_W-1:0] wr_data,
    input  logic                          wr_clear,
    input  logic                          rsv_en,
    input  logic [ADDR_W-1:0]             rsv_addr,
    output logic                          busy1,
    output logic                          busy2,
    input  logic [DATA_W-1:0]             block_id,
    input  logic [DATA_W-1:0]             threads_per_block,
    output logic                          err_ro_write,
    output logic                          err_double_rsv
);

    localparam int                GP_REGS = gp_regs(NUM_REGS);
    localparam logic [ADDR_W-1:0] GP_LIM  = ADDR_W'(GP_REGS);

    logic [GP_REGS-1:0] sb_q, sb_d;
    logic               rd_valid_q;
    logic               err_ro_q, err_ro_d;
    logic               err_rsv_q, err_rsv_d;
    logic               wr_gp, rsv_gp, clear_hit;

    assign wr_gp     = wr_addr < GP_LIM;
    assign rsv_gp    = rsv_addr < GP_LIM;
    assign clear_hit = wr_en && wr_clear && wr_gp;

    // Clear first, then set: a reservation landing on the same address as a
    // load writeback is a fresh request and must survive.
    always_comb begin
        sb_d = sb_q;
        if (clear_hit)
            sb_d[wr_addr] = 1'b0;
        if (rsv_en && rsv_gp)
            sb_d[rsv_addr] = 1'b1;
        err_ro_d  = wr_en && !wr_gp;
        err_rsv_d = rsv_en && rsv_gp && sb_q[rsv_addr]
                    && !(clear_hit && (wr_addr == rsv_addr));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q       <= '0;
            rd_valid_q <= 1'b0;
            err_ro_q   <= 1'b0;
            err_rsv_q  <= 1'b0;
        end else begin
            sb_q       <= sb_d;
            rd_valid_q <= rd_en;
            err_ro_q   <= err_ro_d;
            err_rsv_q  <= err_rsv_d;
        end
    end

    assign busy1          = (rd_addr1 < GP_LIM) && sb_q[rd_addr1];
    assign busy2          = (rd_addr2 < GP_LIM) && sb_q[rd_addr2];
    assign rd_valid       = rd_valid_q;
    assign err_ro_write   = err_ro_q;
    assign err_double_rsv = err_rsv_q;

    for (genvar i = 0; i < NUM_THREADS; i++) begin : g_lane
        lane_regbank #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .LANE_ID  (i),
            .ADDR_W   (ADDR_W)
        ) u_lane (
            .clk               (clk),
            .reset             (reset),
            .rd_en             (rd_en),
            .rd_addr1          (rd_addr1),
            .rd_addr2          (rd_addr2),
            .wr_we             (wr_en && wr_mask[i] && wr_gp),
            .wr_addr           (wr_addr),
            .wr_data           (wr_data[i*DATA_W +: DATA_W]),
            .block_id          (block_id),
            .threads_per_block (threads_per_block),
            .rd_data1          (rd_data1[i*DATA_W +: DATA_W]),
            .rd_data2          (rd_data2[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_thread_regfile_bank.sv
// Self-checking bench for thread_regfile_bank: reference model with a queue of
// expected read results, directed scenarios plus a randomized back-to-back run.
module tb_thread_regfile_bank;

    localparam int DW = 8;
    localparam int NR = 16;
    localparam int NT = 4;
    localparam int AW = 4;
    localparam int GP = NR - 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic              rd_en, wr_en, wr_clear, rsv_en;
    logic [NT-1:0]     wr_mask;
    logic [NT*DW-1:0]  wr_data;
    logic [DW-1:0]     block_id, threads_per_block;
    logic [NT*DW-1:0]  rd_data1, rd_data2;
    logic              rd_valid, busy1, busy2, err_ro_write, err_double_rsv;

    thread_regfile_bank #(.DATA_W(DW), .NUM_REGS(NR), .NUM_THREADS(NT)) dut (
        .clk               (clk),
        .reset             (reset),
        .rd_addr1          (rd_addr1),
        .rd_addr2          (rd_addr2),
        .rd_en             (rd_en),
        .rd_data1          (rd_data1),
        .rd_data2          (rd_data2),
        .rd_valid          (rd_valid),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_mask           (wr_mask),
        .wr_data           (wr_data),
        .wr_clear          (wr_clear),
        .rsv_en            (rsv_en),
        .rsv_addr          (rsv_addr),
        .busy1             (busy1),
        .busy2             (busy2),
        .block_id          (block_id),
        .threads_per_block (threads_per_block),
        .err_ro_write      (err_ro_write),
        .err_double_rsv    (err_double_rsv)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NT*DW-1:0] d1;
        logic [NT*DW-1:0] d2;
    } rd_exp_t;

    rd_exp_t       exp_q[$];
    rd_exp_t       e;
    logic [DW-1:0] mdl [NT][NR];
    logic [NR-1:0] mdl_sb;
    logic          exp_valid, exp_ro, exp_dbl;
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic logic [NT*DW-1:0] mdl_read(input logic [AW-1:0] a);
        logic [NT*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NT; i++) begin
            if (int'(a) < GP) begin
                if (wr_en && wr_mask[i] && wr_addr == a)
                    v[i*DW +: DW] = wr_data[i*DW +: DW];
                else
                    v[i*DW +: DW] = mdl[i][a];
            end else if (int'(a) == NR - 3) v[i*DW +: DW] = block_id;
            else if (int'(a) == NR - 2)     v[i*DW +: DW] = threads_per_block;
            else                            v[i*DW +: DW] = DW'(i);
        end
        return v;
    endfunction

    function automatic logic mdl_busy(input logic [AW-1:0] a);
        return (int'(a) < GP) ? mdl_sb[a] : 1'b0;
    endfunction

    task automatic idle();
        rd_en = 0; wr_en = 0; wr_clear = 0; rsv_en = 0;
        rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; rsv_addr = '0;
        wr_mask = '0; wr_data = '0;
    endtask

    // Predicts this edge's effects, advances the model, clocks the DUT.
    task automatic tick();
        logic clr;
        clr = wr_en && wr_clear && int'(wr_addr) < GP;
        if (!reset && rd_en)
            exp_q.push_back('{mdl_read(rd_addr1), mdl_read(rd_addr2)});
        exp_valid = !reset && rd_en;
        exp_ro    = !reset && wr_en && int'(wr_addr) >= GP;
        exp_dbl   = !reset && rsv_en && int'(rsv_addr) < GP && mdl_sb[rsv_addr]
                    && !(clr && wr_addr == rsv_addr);
        if (reset) begin
            for (int i = 0; i < NT; i++)
                for (int r = 0; r < NR; r++) mdl[i][r] = '0;
            mdl_sb = '0;
            exp_q.delete();
        end else begin
            if (wr_en && int'(wr_addr) < GP)
                for (int i = 0; i < NT; i++)
                    if (wr_mask[i]) mdl[i][wr_addr] = wr_data[i*DW +: DW];
            if (clr) mdl_sb[wr_addr] = 1'b0;
            if (rsv_en && int'(rsv_addr) < GP) mdl_sb[rsv_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        block_id = 8'h07; threads_per_block = 8'h04;
        reset = 1;
        tick(); tick();
        reset = 0;
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", rd_valid); end
        n_tests++; if (rd_data1 !== '0) begin n_fail++; $display("FAIL reset_data1 got %h want 0", rd_data1); end
        n_tests++; if (rd_data2 !== '0) begin n_fail++; $display("FAIL reset_data2 got %h want 0", rd_data2); end
        n_tests++; if (err_ro_write !== 1'b0 || err_double_rsv !== 1'b0) begin
            n_fail++; $display("FAIL reset_err got %0b%0b want 00", err_ro_write, err_double_rsv); end
        n_tests++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %0b%0b want 00", busy1, busy2); end
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1; wr_addr = 2; wr_mask = 4'b1111; wr_data = 32'h44332211;
        tick();
        idle();
        rd_en = 1; rd_addr1 = 2; rd_addr2 = 0;
        tick();
        n_tests++; if (rd_valid !== exp_valid) begin n_fail++; $display("FAIL wr_rd_valid got %0b want %0b", rd_valid, exp_valid); end
        if (rd_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++; if (rd_data1 !== e.d1) begin n_fail++; $display("FAIL wr_rd_d1 got %h want %h", rd_data1, e.d1); end
            n_tests++; if (rd_data2 !== e.d2) begin n_fail++; $display("FAIL wr_rd_d2 got %h want %h", rd_data2, e.d2); end
        end
        n_tests++; if (rd_data1 !== 32'h44332211) begin n_fail++; $display("FAIL wr_rd_lit got %h want 44332211", rd_data1); end
        idle();
        tick();
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_valid_low got %0b want 0", rd_valid); end
    endtask

    task automatic test_forward();
        idle();
        wr_en = 1; wr_addr = 5; wr_mask = 4'b1111; wr_data = 32'h55555555;
        tick();
        idle();
        wr_en = 1; wr_addr = 5; wr_mask = 4'b0101; wr_data = 32'hAAAAAAAA;
        rd_en = 1; rd_addr1 = 2; rd_addr2 = 5;
        tick();
        n_tests++; if (rd_valid !== exp_valid) begin n_fail++; $display("FAIL fwd_valid got %0b want %0b", rd_valid, exp_valid); end
        if (rd_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++; if (rd_data2 !== e.d2) begin n_fail++; $display("FAIL fwd_d2 got %h want %h", rd_data2, e.d2); end
        end
        n_tests++; if (rd_data2 !== 32'h55AA55AA) begin n_fail++; $display("FAIL fwd_lit got %h want 55aa55aa", rd_data2); end
        idle();
        rd_en = 1; rd_addr2 = 5;
        tick();
        if (rd_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++; if (rd_data2 !== e.d2) begin n_fail++; $display("FAIL fwd_stored got %h want %h", rd_data2, e.d2); end
        end
    endtask

    task automatic test_ro();
        idle();
        rd_en = 1; rd_addr1 = 13; rd_addr2 = 15;
        tick();
        if (rd_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++; if (rd_data1 !== e.d1) begin n_fail++; $display("FAIL ro_bid got %h want %h", rd_data1, e.d1); end
            n_tests++; if (rd_data2 !== 32'h03020100) begin n_fail++; $display("FAIL ro_tid got %h want 03020100", rd_data2); end
        end else begin
            n_tests++; n_fail++; $display("FAIL ro_valid got %0b want 1", rd_valid);
        end
        idle();
        wr_en = 1; wr_addr = 14; wr_mask = 4'b1111; wr_data = 32'h99999999;
        tick();
        n_tests++; if (err_ro_write !== exp_ro || exp_ro !== 1'b1) begin
            n_fail++; $display("FAIL ro_err got %0b want 1", err_ro_write); end
        n_tests++; if (rd_data1 !== 32'h07070707) begin n_fail++; $display("FAIL ro_hold got %h want 07070707", rd_data1); end
        idle();
        rd_en = 1; rd_addr1 = 14;
        tick();
        n_tests++; if (err_ro_write !== 1'b0) begin n_fail++; $display("FAIL ro_err_pulse got %0b want 0", err_ro_write); end
        if (rd_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++; if (rd_data1 !== 32'h04040404 || rd_data1 !== e.d1) begin
                n_fail++; $display("FAIL ro_tpb got %h want 04040404", rd_data1); end
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rd_addr1 = 3; rsv_en = 1; rsv_addr = 3;
        #1;
        n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_same_cycle got %0b want 0", busy1); end
        tick();
        rsv_en = 0;
        #1;
        n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_set got %0b want 1", busy1); end
        n_tests++; if (err_double_rsv !== 1'b0) begin n_fail++; $display("FAIL sb_noerr got %0b want 0", err_double_rsv); end
        rsv_en = 1;
        tick();
        n_tests++; if (err_double_rsv !== 1'b1 || exp_dbl !== 1'b1) begin
            n_fail++; $display("FAIL sb_double got %0b want 1", err_double_rsv); end
        idle();
        rd_addr1 = 3; rd_addr2 = 13; rsv_en = 1; rsv_addr = 13;
        tick();
        n_tests++; if (err_double_rsv !== 1'b0 || busy1 !== 1'b1) begin
            n_fail++; $display("FAIL sb_pulse got err=%0b busy=%0b want 0 1", err_double_rsv, busy1); end
        n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL sb_ro_busy got %0b want 0", busy2); end
        idle();
        rd_addr1 = 3; wr_en = 1; wr_clear = 1; wr_addr = 3; wr_mask = 4'b0000; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_addr1 = 3;
        #1;
        n_tests++; if (busy1 !== mdl_busy(3) || busy1 !== 1'b0) begin
            n_fail++; $display("FAIL sb_clear got %0b want 0", busy1); end
    endtask

    task automatic test_rsv_clear();
        idle();
        rd_addr1 = 6; rsv_en = 1; rsv_addr = 6;
        wr_en = 1; wr_clear = 1; wr_addr = 6; wr_mask = 4'b1111; wr_data = 32'h66666666;
        tick();
        idle();
        rd_addr1 = 6;
        #1;
        n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL rsvclr_busy got %0b want 1", busy1); end
        n_tests++; if (err_double_rsv !== 1'b0) begin n_fail++; $display("FAIL rsvclr_err got %0b want 0", err_double_rsv); end
        wr_en = 1; wr_clear = 1; wr_addr = 6;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 60; c++) begin
            rd_en    = ($urandom_range(0, 3) != 0);
            rd_addr1 = AW'($urandom_range(0, NR - 1));
            rd_addr2 = AW'($urandom_range(0, NR - 1));
            wr_en    = $urandom_range(0, 1) == 1;
            wr_addr  = ($urandom_range(0, 2) == 0) ? rd_addr1 : AW'($urandom_range(0, NR - 1));
            wr_mask  = NT'($urandom_range(0, 15));
            wr_data  = $urandom;
            wr_clear = $urandom_range(0, 1) == 1;
            rsv_en   = $urandom_range(0, 2) == 0;
            rsv_addr = AW'($urandom_range(0, NR - 1));
            tick();
            n_tests++; if (rd_valid !== exp_valid) begin n_fail++; $display("FAIL b2b_valid c=%0d got %0b want %0b", c, rd_valid, exp_valid); end
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++; $display("FAIL b2b_underflow c=%0d got valid want none", c);
                end else begin
                    e = exp_q.pop_front();
                    n_tests++; if (rd_data1 !== e.d1 || rd_data2 !== e.d2) begin
                        n_fail++; $display("FAIL b2b_data c=%0d got %h/%h want %h/%h", c, rd_data1, rd_data2, e.d1, e.d2); end
                end
            end
            n_tests++; if (err_ro_write !== exp_ro || err_double_rsv !== exp_dbl) begin
                n_fail++; $display("FAIL b2b_err c=%0d got %0b%0b want %0b%0b", c, err_ro_write, err_double_rsv, exp_ro, exp_dbl); end
            n_tests++; if (busy1 !== mdl_busy(rd_addr1) || busy2 !== mdl_busy(rd_addr2)) begin
                n_fail++; $display("FAIL b2b_busy c=%0d got %0b%0b want %0b%0b", c, busy1, busy2, mdl_busy(rd_addr1), mdl_busy(rd_addr2)); end
        end
        idle();
        tick();
        exp_q.delete();
    endtask

    task automatic test_reset_inflight();
        idle();
        wr_en = 1; wr_addr = 2; wr_mask = 4'b1111; wr_data = 32'h12345678;
        rsv_en = 1; rsv_addr = 7;
        tick();
        idle();
        rd_en = 1; rd_addr1 = 2; rd_addr2 = 7;
        wr_en = 1; wr_addr = 7; wr_mask = 4'b1111; wr_data = 32'hFFFFFFFF;
        rsv_en = 1; rsv_addr = 8;
        reset = 1;
        tick();
        reset = 0;
        idle();
        rd_addr1 = 7; rd_addr2 = 8;
        #1;
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstfl_valid got %0b want 0", rd_valid); end
        n_tests++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL rstfl_busy got %0b%0b want 00", busy1, busy2); end
        rd_en = 1; rd_addr1 = 2; rd_addr2 = 7;
        tick();
        idle();
        if (rd_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++; if (rd_data1 !== '0 || rd_data2 !== '0 || e.d1 !== '0) begin
                n_fail++; $display("FAIL rstfl_data got %h/%h want 0/0", rd_data1, rd_data2); end
        end else begin
            n_tests++; n_fail++; $display("FAIL rstfl_read got valid=%0b want 1", rd_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mdl_sb = '0;
        exp_valid = 0; exp_ro = 0; exp_dbl = 0;
        test_reset();
        test_write_read();
        test_forward();
        test_ro();
        test_scoreboard();
        test_rsv_clear();
        test_back_to_back();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
